// File: rtl/seg_scan_ctrl_if.sv
// Display-side bus of the scan controller: cathode patterns and controls in,
// multiplexed anode/cathode drive and frame marker out.
interface seg_scan_ctrl_if #(
  parameter int unsigned DIGITS = 8
);
  logic [DIGITS*8-1:0] display;
  logic [DIGITS-1:0]   digit_en;
  logic [3:0]          brightness;
  logic [DIGITS-1:0]   anode;
  logic [7:0]          cathode;
  logic                frame_start;

  modport master (
    output display, digit_en, brightness,
    input  anode, cathode, frame_start
  );

  modport slave (
    input  display, digit_en, brightness,
    output anode, cathode, frame_start
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner: per-frame snapshot of the cathode bus, guarded
// digit slots and a 16-level brightness window inside each slot.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 1000,
  parameter int unsigned GUARD      = 16
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int unsigned SLOT = CLK_HZ / (REFRESH_HZ * DIGITS);
  localparam int unsigned CntW = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (SLOT <= GUARD + 1) begin : g_slot_check
    $error("seg_scan_ctrl: SLOT must exceed GUARD+1");
  end

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [DIGITS*8-1:0] shadow_disp_q;
  logic [DIGITS-1:0]   shadow_en_q;
  logic [3:0]          shadow_bright_q;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]          cathode_q, cathode_d;
  logic                frame_start_q;
  logic                snap;
  logic                lit;
  logic [31:0]         on_len;
  logic [31:0]         cnt_ext;

  always_comb begin
    snap  = (cnt_q == '0) && (idx_q == '0);
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_q == CntW'(SLOT - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
  end

  // On-window length scales the post-guard part of the slot by (level+1)/16.
  always_comb begin
    on_len    = ((SLOT - GUARD) * (32'(shadow_bright_q) + 32'd1)) >> 4;
    cnt_ext   = 32'(cnt_q);
    lit       = (cnt_ext >= GUARD) && (cnt_ext < GUARD + on_len) && shadow_en_q[idx_q];
    anode_d   = '1;
    cathode_d = 8'hFF;
    if (lit) begin
      anode_d[idx_q] = 1'b0;
      cathode_d      = shadow_disp_q[idx_q*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q           <= '0;
      idx_q           <= '0;
      shadow_disp_q   <= '1;
      shadow_en_q     <= '0;
      shadow_bright_q <= '0;
      anode_q         <= '1;
      cathode_q       <= 8'hFF;
      frame_start_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
      frame_start_q <= snap;
      // Snapshot only at frame start so a frame never mixes old and new patterns.
      if (snap) begin
        shadow_disp_q   <= bus.display;
        shadow_en_q     <= bus.digit_en;
        shadow_bright_q <= bus.brightness;
      end
    end
  end

  assign bus.anode       = anode_q;
  assign bus.cathode     = cathode_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them and checks scan invariants.
module tb_seg_scan_ctrl;
  localparam int unsigned DIGITS     = 4;
  localparam int unsigned CLK_HZ     = 6400;
  localparam int unsigned REFRESH_HZ = 100;
  localparam int unsigned GUARD      = 2;
  localparam int unsigned SLOT       = 16;
  localparam int unsigned FRAME      = SLOT * DIGITS;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .DIGITS    (DIGITS),
    .CLK_HZ    (CLK_HZ),
    .REFRESH_HZ(REFRESH_HZ),
    .GUARD     (GUARD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  anode;
    logic [7:0]  cathode;
    logic        fs;
    logic [31:0] t;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int t = 0;

  // Frame contents the bench expects the DUT to be showing.
  logic [31:0] m_disp = '1;
  logic [3:0]  m_en   = '0;
  logic [3:0]  m_b    = '0;

  // Expected output after edge t: before that edge the slot position was t-1.
  task automatic tick();
    int   p, c, idx, onlen;
    exp_t e;
    @(posedge clk);
    #1;
    t++;
    e.anode   = '1;
    e.cathode = 8'hFF;
    e.fs      = 1'b0;
    e.t       = t;
    if (rst) begin
      p     = (t - 1) % FRAME;
      c     = p % SLOT;
      idx   = p / SLOT;
      onlen = ((SLOT - GUARD) * (int'(m_b) + 1)) / 16;
      if (c >= GUARD && c < GUARD + onlen && m_en[idx]) begin
        e.anode[idx] = 1'b0;
        e.cathode    = m_disp[idx*8 +: 8];
      end
      if (p == 0) begin
        e.fs   = 1'b1;
        m_disp = bus.display;
        m_en   = bus.digit_en;
        m_b    = bus.brightness;
      end
    end
    q.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int         dark_run = 100;
  logic [3:0] last_lit = '1;

  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (bus.anode !== e.anode || bus.cathode !== e.cathode || bus.frame_start !== e.fs) begin
        errors++;
        $display("FAIL scan t=%0d: got anode=%b cathode=%h fs=%b, want anode=%b cathode=%h fs=%b",
                 e.t, bus.anode, bus.cathode, bus.frame_start, e.anode, e.cathode, e.fs);
      end
    end
    checks++;
    if ($countones(~bus.anode) > 1) begin
      errors++;
      $display("FAIL onehot: got anode=%b, want at most one low", bus.anode);
    end
    checks++;
    if (bus.anode === 4'hF && bus.cathode !== 8'hFF) begin
      errors++;
      $display("FAIL idle_cathode: got cathode=%h, want ff", bus.cathode);
    end
    if (bus.anode !== 4'hF) begin
      if (bus.anode !== last_lit) begin
        checks++;
        if (dark_run < int'(GUARD)) begin
          errors++;
          $display("FAIL guard_gap: got gap=%0d before anode=%b, want >= %0d",
                   dark_run, bus.anode, GUARD);
        end
      end
      last_lit = bus.anode;
      dark_run = 0;
    end else begin
      dark_run++;
    end
  end

  initial begin
    bus.display    = 32'hC0F9A4B0;
    bus.digit_en   = 4'hF;
    bus.brightness = 4'd15;
    ticks(3);
    rst = 1'b1;
    t   = 0;

    // Full brightness, all digits, two frames.
    ticks(2 * FRAME);
    bus.brightness = 4'd7;
    ticks(FRAME);
    bus.brightness = 4'd0;
    ticks(FRAME);

    bus.brightness = 4'd15;
    bus.digit_en   = 4'b0101;
    ticks(FRAME);

    // Mid-frame change lands at cnt=5, idx=1 and must wait for the next frame.
    bus.digit_en = 4'hF;
    ticks(21);
    bus.display = 32'hFFFFFFFF;
    ticks(FRAME - 21 + FRAME);

    bus.digit_en = 4'h0;
    ticks(FRAME);

    // Reset inside digit 2's on-window.
    bus.display  = 32'hC0F9A4B0;
    bus.digit_en = 4'hF;
    ticks(FRAME + 38);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.anode !== 4'hF || bus.cathode !== 8'hFF || bus.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got anode=%b cathode=%h fs=%b, want 1111 ff 0",
               bus.anode, bus.cathode, bus.frame_start);
    end
    ticks(3);
    rst = 1'b1;
    t   = 0;
    ticks(FRAME);

    // Random inputs changed at a random point in each frame.
    for (int f = 0; f < 1000; f++) begin
      int r;
      r = $urandom_range(FRAME - 1, 1);
      ticks(r);
      bus.display    = $urandom;
      bus.digit_en   = 4'($urandom);
      bus.brightness = 4'($urandom);
      ticks(FRAME - r);
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 8-segment display bus produced by `seg_display`. It drives one shared cathode byte and DIGITS active-low anodes.
- It latches a tear-free snapshot of the flattened cathode bus once per frame and steps through the digits at a fixed refresh rate.
- Each digit slot contains a ghosting guard interval and a 16-level brightness PWM window.
- It sits between `seg_display` and the board pins.

Parameters:
- DIGITS, 8, number of digits scanned; matches the display bus width of DIGITS*8.
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- REFRESH_HZ, 1000, full-frame refresh rate in Hz.
- GUARD, 16, clock cycles at the start of each slot with all anodes off.
- SLOT (localparam), CLK_HZ/(REFRESH_HZ*DIGITS), cycles per digit slot.
  - Elaboration error if SLOT <= GUARD+1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- display, input, DIGITS*8, cathode patterns, 8 bits per digit, digit i at [i*8+:8], active-low segments.
- digit_en, input, DIGITS, per-digit enable mask; 0 blanks that digit.
- brightness, input, 4, duty level 0..15.
- anode, output, DIGITS, active-low digit select; at most one bit low.
- cathode, output, 8, active-low segment/dp drive.
- frame_start, output, 1, one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (rst=0, asynchronous):
  - anode = all 1s, cathode = 8'hFF, frame_start = 0.
  - cnt = 0, idx = 0.
  - shadow display = all 1s, shadow enable = 0, shadow brightness = 0.
- Counters:
  - cnt runs 0..SLOT-1 and wraps to 0.
  - On wrap, idx increments; idx wraps from DIGITS-1 to 0.
- Snapshot:
  - On the cycle with cnt==0 and idx==0 (including the first cycle after reset release), capture display, digit_en and brightness into shadow registers.
  - frame_start is registered: it is high in the cycle after that edge.
  - Input changes mid-frame have no visible effect until the next snapshot.
- On-window:
  - on_len = ((SLOT-GUARD)*(shadow_brightness+1)) >> 4, computed at full width with no overflow.
  - The digit is lit when GUARD <= cnt < GUARD+on_len and shadow_en[idx]==1.
- Outputs are registered; values computed from cnt/idx at cycle k appear at cycle k+1.
  - When lit: anode[idx]=0, other anode bits 1, cathode = shadow_display[idx*8+:8].
  - When not lit: anode all 1s, cathode = 8'hFF.
- Boundary conditions:
  - on_len==0: the digit stays dark for the whole slot.
  - A disabled digit still consumes its full slot, so the scan period stays uniform.
  - All digits disabled: outputs stay idle; frame_start still pulses every frame.
  - Never more than one anode low in any cycle; a gap of at least GUARD cycles separates successive lit digits.
  - Reset asserted mid-slot: outputs go idle immediately (asynchronous). After release, scanning restarts at idx 0, cnt 0, with a fresh snapshot.

Test Plan (bench parameters: DIGITS=4, CLK_HZ=6400, REFRESH_HZ=100, GUARD=2, giving SLOT=16):
1. Reset release, brightness=15, digit_en=4'hF, display=32'hC0F9A4B0:
   - frame_start pulses once.
   - Digit 0: anode=4'b1110 and cathode=8'hB0 for cycles 3..16 after release (14 cycles).
   - Digit 1: anode=4'b1101 and cathode=8'hA4 for cycles 19..32.
   - Digits 2 and 3 follow the same pattern; the frame repeats every 64 cycles.
2. brightness=7 → lit 7 cycles per slot (cnt 2..8); brightness=0 → anode stays all 1s throughout.
3. digit_en=4'b0101 → only digits 0 and 2 are lit; digit 1 and 3 slots are fully dark; the period stays 64 cycles.
4. Change display to 32'hFFFFFFFF at cnt=5, idx=1:
   - The remaining slots of the current frame still show the old values.
   - The new values appear starting with the next frame's digit 0, immediately after the next frame_start pulse.
5. Assert rst during digit 2's on-window:
   - anode goes to all 1s and cathode to FF in the same cycle, with no clock edge needed.
   - After release, digit 0 is lit first, at cycle 3.
6. Randomized inputs over 1000 frames:
   - Assertion: $countones(~anode) <= 1 in every cycle.
   - Assertion: cathode==8'hFF whenever anode is all 1s.
